// File: rtl/lsu32_pkg.sv
// Shared constants and types for the 32-bit load/store unit.
// Holds the funct3 size/sign encodings and the sequencing state enum.
package gpc_lsu_pkg;

    localparam int LSU_WIDTH = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu32_if.sv
// Data-memory port of the load/store unit: valid/ready request, one-cycle response.
// The LSU side is the master; the memory or bus fabric is the slave.
interface lsu32_if #(
    parameter int WIDTH = 32
);
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [3:0]       mem_wstrb;
    logic             mem_rsp_valid;
    logic [WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req_valid,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req_valid,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rdata
    );

endinterface

// File: rtl/lsu32_align.sv
// Combinational size/alignment check, store lane placement and load extract/extend.
// The request side works on the incoming request; the read side on the latched one.
module lsu_align
    import gpc_lsu_pkg::*;
(
    input  logic        load_en,
    input  logic        store_en,
    input  logic [1:0]  req_off,
    input  logic [2:0]  req_f3,
    input  logic [31:0] req_data,
    output logic        req_legal,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    input  logic [1:0]  rd_off,
    input  logic [2:0]  rd_f3,
    input  logic [31:0] rdata,
    output logic [31:0] rd_ext
);

    logic        size_ok;
    logic        align_ok;
    logic [31:0] rd_shift;

    // Unsigned sizes exist only for loads.
    always_comb begin
        size_ok  = 1'b0;
        align_ok = 1'b0;
        unique case (req_f3)
            F3_B:  begin size_ok = 1'b1;    align_ok = 1'b1;            end
            F3_BU: begin size_ok = load_en; align_ok = 1'b1;            end
            F3_H:  begin size_ok = 1'b1;    align_ok = ~req_off[0];     end
            F3_HU: begin size_ok = load_en; align_ok = ~req_off[0];     end
            F3_W:  begin size_ok = 1'b1;    align_ok = (req_off == 2'b00); end
            default: begin size_ok = 1'b0;  align_ok = 1'b0;            end
        endcase
        req_legal = (load_en ^ store_en) & size_ok & align_ok;
    end

    always_comb begin
        wstrb = 4'b0000;
        unique case (req_f3)
            F3_B:    wstrb = 4'b0001 << req_off;
            F3_H:    wstrb = 4'b0011 << req_off;
            F3_W:    wstrb = 4'b1111;
            default: wstrb = 4'b0000;
        endcase
        wdata = req_data << {req_off, 3'b000};
    end

    always_comb begin
        rd_shift = rdata >> {rd_off, 3'b000};
        unique case (rd_f3)
            F3_B:    rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            F3_BU:   rd_ext = {24'd0, rd_shift[7:0]};
            F3_H:    rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            F3_HU:   rd_ext = {16'd0, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

endmodule

// File: rtl/lsu32.sv
// Load/store unit between the execute stage and data memory: one request at a time,
// word-aligned byte-strobed bus access, extended load data with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for load_en/store_en; illegal requests answered here with done+err
// REQ   | mem_req_valid high, all mem_* outputs frozen until mem_req_ready
// RSP   | waiting for mem_rsp_valid; completion reported on the following cycle
module lsu32
    import gpc_lsu_pkg::*;
#(
    parameter int WIDTH = LSU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_addr,
    input  logic             store_en,
    input  logic [WIDTH-1:0] store_addr,
    input  logic [WIDTH-1:0] store_data,
    input  logic [2:0]       funct3,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] load_data,
    lsu32_if.master          mem
);

    lsu_state_t state_q;
    lsu_state_t state_next;

    logic        accept;
    logic        reject;
    logic        finish;
    logic        req_valid;

    logic [31:0] req_addr;
    logic        req_legal;
    logic [3:0]  wstrb_new;
    logic [31:0] wdata_new;
    logic [31:0] rd_ext;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        we_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] load_data_q;

    // With both enables high the request is illegal anyway, so the mux choice is moot.
    assign req_addr = store_en ? store_addr : load_addr;

    lsu_align u_align (
        .load_en   (load_en),
        .store_en  (store_en),
        .req_off   (req_addr[1:0]),
        .req_f3    (funct3),
        .req_data  (store_data),
        .req_legal (req_legal),
        .wstrb     (wstrb_new),
        .wdata     (wdata_new),
        .rd_off    (off_q),
        .rd_f3     (f3_q),
        .rdata     (mem.mem_rdata),
        .rd_ext    (rd_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_next;
    end

    always_comb begin
        state_next = state_q;
        accept     = 1'b0;
        reject     = 1'b0;
        finish     = 1'b0;
        req_valid  = 1'b0;
        busy       = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (load_en || store_en) begin
                    if (req_legal) begin
                        accept     = 1'b1;
                        state_next = ST_REQ;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                req_valid = 1'b1;
                if (mem.mem_req_ready) state_next = ST_RSP;
            end
            ST_RSP: begin
                if (mem.mem_rsp_valid) begin
                    finish     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                busy       = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // Bus fields are captured once at acceptance so they cannot move while REQ waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            we_q        <= 1'b0;
            off_q       <= '0;
            f3_q        <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            load_data_q <= '0;
        end else begin
            done_q <= reject | finish;
            err_q  <= reject;
            if (accept) begin
                addr_q  <= {req_addr[31:2], 2'b00};
                off_q   <= req_addr[1:0];
                f3_q    <= funct3;
                we_q    <= store_en;
                wstrb_q <= store_en ? wstrb_new : 4'b0000;
                wdata_q <= store_en ? wdata_new : 32'd0;
            end
            if (finish && !we_q) load_data_q <= rd_ext;
        end
    end

    assign done      = done_q;
    assign err       = err_q;
    assign load_data = load_data_q;

    assign mem.mem_req_valid = req_valid;
    assign mem.mem_we        = we_q;
    assign mem.mem_addr      = addr_q;
    assign mem.mem_wdata     = wdata_q;
    assign mem.mem_wstrb     = wstrb_q;

endmodule

// File: doc/lsu32.md
# lsu32

Load/store unit that is the responder to the execute stage's `load_en/load_addr` and `store_en/store_addr` request outputs. It accepts one memory request at a time and checks the `funct3` size and alignment. It issues a word-aligned, byte-strobed access on a valid/ready data-memory port, then returns sign- or zero-extended load data with a one-cycle `done` pulse. It sits between the EXU and the data memory/bus.

## Interface
- `WIDTH`, 32, datapath and address width; only 32 is supported.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load_en` in 1: load request, sampled only in IDLE.
- `load_addr` in WIDTH: load byte address.
- `store_en` in 1: store request, sampled only in IDLE.
- `store_addr` in WIDTH: store byte address.
- `store_data` in WIDTH: store value, right-aligned.
- `funct3` in 3: access size and sign.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: qualifies `done`; high means the request was rejected and no bus access was made.
- `load_data` out WIDTH: extended load result; holds until the next successful load.
- `mem_req_valid` out 1: memory request valid.
- `mem_req_ready` in 1: memory request ready.
- `mem_we` out 1: 1 = write.
- `mem_addr` out WIDTH: `{addr[31:2], 2'b00}`.
- `mem_wdata` out WIDTH: store data shifted to its byte lane.
- `mem_wstrb` out 4: byte enables (0 for reads).
- `mem_rsp_valid` in 1: response or write acknowledge, one cycle.
- `mem_rdata` in WIDTH: read word.

## Operation
- States: IDLE, REQ, RSP.
- IDLE with a legal request: latch address, data, `funct3` and direction, then go to REQ.
- IDLE with an illegal request: next cycle `done=1`, `err=1`; stay in IDLE.
- Illegal requests are:
  - `load_en` and `store_en` both high.
  - `funct3` not in {000, 001, 010, 100, 101} for loads.
  - `funct3` not in {000, 001, 010} for stores.
  - Halfword access with `addr[0]=1`.
  - Word access with `addr[1:0]≠0`.
- REQ: `mem_req_valid=1`, with all `mem_*` outputs held stable until `mem_req_ready`. On the handshake go to RSP.
- RSP: wait for `mem_rsp_valid`. On it, go to IDLE and assert `done=1`, `err=0` in the next cycle.
  - For loads, `load_data` updates in the same cycle as `done`.
- Write strobes, with `o=addr[1:0]`:
  - SB: `4'b0001<<o`.
  - SH: `4'b0011<<o`.
  - SW: `4'b1111`.
  - `mem_wdata = store_data << (8*o)`.
- Load extraction: select the byte or halfword at offset `o` from `mem_rdata`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Ignored inputs:
  - `mem_rsp_valid` in IDLE or REQ (stray response).
  - `load_en`/`store_en` while busy. The EXU holds a request until it sees `done`.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`, `mem_req_valid`, `mem_we` = 0; `mem_addr`, `mem_wdata`, `mem_wstrb`, `load_data` = 0.
- Minimum legal latency (zero-wait memory): request at edge 0 → `mem_req_valid` in cycle 1 → `mem_rsp_valid` in cycle 2 → `done` in cycle 3.
- Error latency: `done`/`err` appear 1 cycle after the request.
- A new request can be accepted in the same cycle `done` is high, since the state is already IDLE.
- `mem_req_valid` never drops before ready (no withdrawal).
- Reset asserted mid-transaction: return to IDLE immediately. A late `mem_rsp_valid` after reset is ignored.

## Structure
- Package `gpc_lsu_pkg` holds:
  - The `funct3` constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - The state enum `lsu_state_t`.
- Sub-module `lsu_align` is purely combinational and contains:
  - Legality/alignment check.
  - Write-strobe and data lane shift.
  - Read extract/extend.
- The FSM and registers live in `lsu32`.

## Test plan
- SW at 0x100, data 0xDEADBEEF, memory ready immediately → `mem_addr=0x100`, `wstrb=1111`, `wdata=0xDEADBEEF`; `done` in cycle 3, `err=0`.
- SB at 0x203, data 0x000000A5 → `mem_addr=0x200`, `wstrb=1000`, `wdata=0xA5000000`.
- LB/LBU at 0x301 with `mem_rdata=0x1234F000` → `load_data` is 0xFFFFFFF0 for LB and 0x000000F0 for LBU; LH at 0x302 → 0x00001234.
- LW at 0x102 → `done=1`, `err=1` one cycle later, `mem_req_valid` never asserted. Also `load_en` and `store_en` both high → same error response.
- Backpressure: `mem_req_ready` low for 3 cycles → `mem_req_valid` and address/data held stable; `busy` high throughout; exactly one handshake.
- Reset asserted while in RSP, then `mem_rsp_valid` pulsed → all outputs 0, no `done`; a following LW at 0x0 completes normally.
